timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter BITS, default 4, width of period and counter value.
REQ-002 Parameter PRESCALE, default 4, enable divide ratio (≥2), used only when TIMER_CTRL_PRESCALE_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 cfg_valid  input  1  config request.
REQ-006 cfg_ready  output  1  config accept; transfer on cfg_valid && cfg_ready at posedge.
REQ-007 cfg_period  input  BITS  terminal count for the downstream mod counter.
REQ-008 cfg_oneshot  input  1  1 = stop after one wrap, 0 = periodic.
REQ-009 start  input  1  single-cycle run request.
REQ-010 stop  input  1  single-cycle halt request.
REQ-011 cnt_q  input  BITS  current value from the downstream mod counter.
REQ-012 cnt_enable  output  1  drives the counter's enable.
REQ-013 cnt_final  output  BITS  drives the counter's FINAL_VALUE (active period register).
REQ-014 tick  output  1  one-cycle pulse per counter wrap.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  high in DONE.
REQ-017 tick_count  output  8  number of wraps since last start from IDLE.

Function
REQ-018 FSM states IDLE, RUN, DONE; encoding is free.
REQ-019 IDLE: start -> RUN, tick_count cleared to 0 on the same edge.
REQ-020 RUN: stop -> IDLE; wrap with oneshot=1 -> DONE; otherwise stay.
REQ-021 DONE: start -> RUN (tick_count not cleared); stop -> IDLE.
REQ-022 start and stop in the same cycle: stop wins; start alone in RUN is ignored.
REQ-023 Wrap event = cnt_enable && (cnt_q == cnt_final), sampled at posedge.
REQ-024 tick is registered: high exactly the cycle after the wrap edge; never asserted outside RUN-caused wraps.
REQ-025 tick_count increments by 1 on each wrap, mod 256.
REQ-026 cfg_ready = 1 whenever no shadow update is pending.
REQ-027 Config accepted in IDLE or DONE: cnt_final and oneshot register load directly on the accepting edge.
REQ-028 Config accepted in RUN: values go to shadow registers and set pending; applied to cnt_final/oneshot on the next wrap edge, pending cleared same edge.
REQ-029 Config accepted on a wrap edge in RUN is not applied at that wrap; it waits for the following one.
REQ-030 The oneshot decision at a wrap uses the active oneshot value before any shadow update on that edge.
REQ-031 cfg_period = 0 is legal: every enabled cycle is a wrap.
REQ-032 Counter is never cleared by this block; stop leaves cnt_q held, restart resumes from held value.
REQ-033 cnt_enable = 0 in IDLE and DONE.

Reset
REQ-034 On reset_n low, asynchronously: state IDLE, cnt_final 0, oneshot 0, pending 0, tick 0, tick_count 0, prescaler 0.
REQ-035 Reset mid-RUN discards pending shadow config; cfg_ready reads 1 during and after reset.

Configuration
REQ-036 Macro TIMER_CTRL_PRESCALE_EN: when defined, cnt_enable pulses high one cycle in every PRESCALE cycles while in RUN; prescaler restarts at 0 on every entry into RUN, so first pulse occurs PRESCALE cycles after entry.
REQ-037 Without the macro, cnt_enable = 1 for every cycle in RUN; PRESCALE ignored.

Verification
REQ-038 BITS=4, period 3 loaded in IDLE, oneshot 0, start -> tick every 4 cycles, tick_count 1,2,3..., busy=1.
REQ-039 Period 2, oneshot 1, start from cnt_q=0 -> one tick 3 cycles after RUN entry, state DONE, cnt_enable 0, done=1.
REQ-040 RUN at period 5, send period 1 mid-count -> cfg_ready drops, old period completes, next periods are 2 cycles, cfg_ready returns at the wrap.
REQ-041 start and stop asserted same cycle in IDLE -> stays IDLE; stop in RUN at cnt_q=2 -> cnt_enable 0, cnt_q holds 2, restart resumes at 2.
REQ-042 reset_n low mid-RUN with pending config -> all outputs at reset values immediately; after release, new config loads directly.
REQ-043 With TIMER_CTRL_PRESCALE_EN, PRESCALE=4, period 1 -> cnt_enable every 4th cycle, tick every 8 cycles.

Source files
------------

// File: rtl/timer_ctrl.sv
// Run/stop/one-shot controller for an external modulo counter, with shadowed reconfiguration.
// Optional enable prescaler is compiled in when TIMER_CTRL_PRESCALE_EN is defined.
module timer_ctrl #(
  parameter int BITS     = 4,
  parameter int PRESCALE = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [BITS-1:0] cfg_period,
  input  logic            cfg_oneshot,
  input  logic            start,
  input  logic            stop,
  input  logic [BITS-1:0] cnt_q,
  output logic            cnt_enable,
  output logic [BITS-1:0] cnt_final,
  output logic            tick,
  output logic            busy,
  output logic            done,
  output logic [7:0]      tick_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic            oneshot, pending, sh_oneshot;
  logic [BITS-1:0] sh_period;
  logic            wrap, accept;

`ifdef TIMER_CTRL_PRESCALE_EN
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre;

  // Held at zero outside RUN so every entry starts a full prescale period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     pre <= '0;
    else if (state != RUN)            pre <= '0;
    else if (pre == PW'(PRESCALE-1))  pre <= '0;
    else                              pre <= pre + 1'b1;
  end

  assign cnt_enable = (state == RUN) && (pre == PW'(PRESCALE-1));
`else
  logic [31:0] unused_prescale;
  assign unused_prescale = 32'(PRESCALE);
  assign cnt_enable      = (state == RUN);
`endif

  assign wrap      = cnt_enable && (cnt_q == cnt_final);
  assign cfg_ready = !pending;
  assign accept    = cfg_valid && !pending;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && !stop) state_nx = RUN;
      RUN:     if (stop) state_nx = IDLE;
               else if (wrap && oneshot) state_nx = DONE;
      DONE:    if (stop) state_nx = IDLE;
               else if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt_final  <= '0;
      oneshot    <= 1'b0;
      pending    <= 1'b0;
      sh_period  <= '0;
      sh_oneshot <= 1'b0;
      tick       <= 1'b0;
      tick_count <= '0;
    end else begin
      state <= state_nx;
      tick  <= wrap;
      if (state == IDLE && state_nx == RUN) tick_count <= '0;
      else if (wrap)                        tick_count <= tick_count + 8'd1;
      // While running, config is staged and only swapped in on a wrap; accept
      // implies nothing was pending, so apply and capture never collide.
      if (state == RUN) begin
        if (wrap && pending) begin
          cnt_final <= sh_period;
          oneshot   <= sh_oneshot;
          pending   <= 1'b0;
        end
        if (accept) begin
          sh_period  <= cfg_period;
          sh_oneshot <= cfg_oneshot;
          pending    <= 1'b1;
        end
      end else if (accept) begin
        cnt_final <= cfg_period;
        oneshot   <= cfg_oneshot;
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios with literal expectations plus random
// stimulus checked every cycle against a behavioural model and a modelled mod counter.
module tb_timer_ctrl;
  localparam int PRESCALE = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       cfg_valid = 1'b0, cfg_ready, cfg_oneshot = 1'b0;
  logic [3:0] cfg_period = '0, cnt_q = '0, cnt_final;
  logic       start = 1'b0, stop = 1'b0, cnt_enable, tick, busy, done;
  logic [7:0] tick_count;

  int total = 0, bad = 0, en_seen = 0;

  // model: mode 0 = idle, 1 = running, 2 = finished
  int m_mode, m_final, m_one, m_pend, m_shp, m_sho, m_tick, m_tc, m_cnt, m_age;

  timer_ctrl #(.BITS(4), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop),
    .cnt_q(cnt_q), .cnt_enable(cnt_enable), .cnt_final(cnt_final), .tick(tick),
    .busy(busy), .done(done), .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_en();
`ifdef TIMER_CTRL_PRESCALE_EN
    return int'(m_mode == 1 && (m_age % PRESCALE) == PRESCALE - 1);
`else
    return int'(m_mode == 1);
`endif
  endfunction

  task automatic m_reset();
    m_mode = 0; m_final = 0; m_one = 0; m_pend = 0; m_shp = 0; m_sho = 0;
    m_tick = 0; m_tc = 0; m_cnt = 0; m_age = 0;
  endtask

  task automatic model_adv(input int s, input int p, input int cv, input int cp, input int co);
    int en, wrap, acc, old_final, old_one;
    en = m_en(); old_final = m_final; old_one = m_one;
    wrap = int'(en != 0 && m_cnt == m_final);
    acc  = int'(cv != 0 && m_pend == 0);
    m_tick = wrap;
    if (wrap != 0) m_tc = (m_tc + 1) % 256;
    if (m_mode == 1) begin
      if (wrap != 0 && m_pend != 0) begin m_final = m_shp; m_one = m_sho; m_pend = 0; end
      if (acc != 0) begin m_shp = cp; m_sho = co; m_pend = 1; end
    end else if (acc != 0) begin
      m_final = cp; m_one = co;
    end
    if (en != 0) m_cnt = (m_cnt == old_final) ? 0 : (m_cnt + 1) % 16;
    case (m_mode)
      0: if (s != 0 && p == 0) begin m_mode = 1; m_tc = 0; m_age = 0; end
      1: if (p != 0) m_mode = 0;
         else if (wrap != 0 && old_one != 0) m_mode = 2;
         else m_age++;
      default: if (p != 0) m_mode = 0;
               else if (s != 0) begin m_mode = 1; m_age = 0; end
    endcase
  endtask

  task automatic check_all();
    if (cnt_enable === 1'b1) en_seen++;
    chk("cnt_enable", 32'(cnt_enable), 32'(m_en()));
    chk("cnt_final", 32'(cnt_final), 32'(m_final));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("busy", 32'(busy), 32'(m_mode == 1));
    chk("done", 32'(done), 32'(m_mode == 2));
    chk("tick_count", 32'(tick_count), 32'(m_tc));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_pend == 0));
  endtask

  // Called at a negedge: check, drive inputs, advance model, move to next negedge.
  task automatic step(input logic s, input logic p, input logic cv,
                      input logic [3:0] cp, input logic co);
    check_all();
    start = s; stop = p; cfg_valid = cv; cfg_period = cp; cfg_oneshot = co;
    cnt_q = 4'(m_cnt);
    model_adv(int'(s), int'(p), int'(cv), int'(cp), int'(co));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  // Asserts reset mid-cycle, checks outputs respond before any clock edge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    start = 0; stop = 0; cfg_valid = 0; cfg_period = 0; cfg_oneshot = 0; cnt_q = 0;
    m_reset();
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_tick_count", 32'(tick_count), 0);
    chk("rst_cnt_final", 32'(cnt_final), 0);
    chk("rst_cnt_enable", 32'(cnt_enable), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    m_reset();
    do_reset();

`ifndef TIMER_CTRL_PRESCALE_EN
    // periodic, period 3: wrap every 4 cycles
    step(0, 0, 1, 4'd3, 0);
    step(1, 0, 0, 4'd0, 0);
    idle(16);
    chk("d1_tick_count", 32'(tick_count), 4);
    chk("d1_tick", 32'(tick), 1);
    chk("d1_busy", 32'(busy), 1);

    // one-shot, period 2
    do_reset();
    step(0, 0, 1, 4'd2, 1);
    step(1, 0, 0, 4'd0, 0);
    idle(3);
    chk("d2_done", 32'(done), 1);
    chk("d2_tick", 32'(tick), 1);
    chk("d2_tick_count", 32'(tick_count), 1);
    chk("d2_cnt_enable", 32'(cnt_enable), 0);
    idle(1);
    chk("d2_tick_gone", 32'(tick), 0);
    chk("d2_still_done", 32'(done), 1);

    // shadowed reconfiguration while running
    do_reset();
    step(0, 0, 1, 4'd5, 0);
    step(1, 0, 0, 4'd0, 0);
    idle(2);
    step(0, 0, 1, 4'd1, 0);
    chk("d3_ready_low", 32'(cfg_ready), 0);
    chk("d3_old_final", 32'(cnt_final), 5);
    idle(3);
    chk("d3_ready_back", 32'(cfg_ready), 1);
    chk("d3_new_final", 32'(cnt_final), 1);
    chk("d3_tick1", 32'(tick_count), 1);
    idle(2);
    chk("d3_tick2", 32'(tick), 1);
    chk("d3_tick_count2", 32'(tick_count), 2);

    // start+stop together, stop/resume
    do_reset();
    step(0, 0, 1, 4'd5, 0);
    step(1, 1, 0, 4'd0, 0);
    chk("d4_stop_wins", 32'(busy), 0);
    step(1, 0, 0, 4'd0, 0);
    idle(1);
    step(0, 1, 0, 4'd0, 0);
    chk("d4_stopped", 32'(busy), 0);
    chk("d4_enable_off", 32'(cnt_enable), 0);
    idle(2);
    chk("d4_hold", 32'(m_cnt), 2);
    step(1, 0, 0, 4'd0, 0);
    idle(4);
    chk("d4_resume_tick", 32'(tick), 1);
    chk("d4_resume_count", 32'(tick_count), 1);

    // reset while a shadow update is pending
    do_reset();
    step(0, 0, 1, 4'd5, 0);
    step(1, 0, 0, 4'd0, 0);
    idle(1);
    step(0, 0, 1, 4'd2, 0);
    chk("d5_pending", 32'(cfg_ready), 0);
    do_reset();
    step(0, 0, 1, 4'd7, 1);
    chk("d5_direct_load", 32'(cnt_final), 7);
`else
    // prescaled: period 1, enable every 4th cycle
    step(0, 0, 1, 4'd1, 0);
    step(1, 0, 0, 4'd0, 0);
    en_seen = 0;
    idle(16);
    chk("d6_enables", 32'(en_seen), 4);
    chk("d6_tick_count", 32'(tick_count), 2);
    chk("d6_busy", 32'(busy), 1);
`endif

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) do_reset();
      else step(1'($urandom_range(7) == 0), 1'($urandom_range(15) == 0),
                1'($urandom_range(3) == 0), 4'($urandom_range(15)),
                1'($urandom_range(1)));
    end
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
